// File: rtl/axi_lite_gpio_slave_if.sv
// AXI4-Lite bus bundle between the bridge master and the GPIO register slave.
// Only the five AXI channels live here; clock, reset and pins stay plain ports.
interface axi_lite_gpio_slave_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite GPIO slave: LED output register, synchronized button inputs,
// W1C rising-edge status and a registered level interrupt.
module axi_lite_gpio_slave #(
  parameter int ADDR_W = 4,
  parameter int IN_W   = 1,
  parameter int OUT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_gpio_slave_if.slave s,
  input  logic [IN_W-1:0]      gpio_in,
  output logic [OUT_W-1:0]     gpio_out,
  output logic                 irq
);
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t           wstate_q, wstate_d;
  rstate_t           rstate_q, rstate_d;
  logic              aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic [1:0]        awsel_q, awsel_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wstrb0_q, wstrb0_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [IN_W-1:0]   stat_q, stat_d, ie_q, ie_d;
  logic [IN_W-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic              irq_q, irq_d;

  logic              aw_hs, w_hs, wr_fire, wr_strb0;
  logic [1:0]        wr_sel;
  logic [7:0]        wr_data;
  logic [IN_W-1:0]   w1c;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  // Address and data may arrive in either order; the held copy wins once captured.
  always_comb begin
    wstate_d = wstate_q;
    aw_cap_d = aw_cap_q;
    w_cap_d  = w_cap_q;
    awsel_d  = awsel_q;
    wdata_d  = wdata_q;
    wstrb0_d = wstrb0_q;
    bvalid_d = bvalid_q;
    wr_fire  = 1'b0;
    aw_hs    = s.awvalid && awready_q;
    w_hs     = s.wvalid && wready_q;
    wr_sel   = aw_cap_q ? awsel_q : s.awaddr[3:2];
    wr_data  = w_cap_q ? wdata_q : s.wdata[7:0];
    wr_strb0 = w_cap_q ? wstrb0_q : s.wstrb[0];
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          awsel_d  = s.awaddr[3:2];
        end
        if (w_hs) begin
          w_cap_d  = 1'b1;
          wdata_d  = s.wdata[7:0];
          wstrb0_d = s.wstrb[0];
        end
        if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
          wr_fire  = 1'b1;
          wstate_d = W_RESP;
          bvalid_d = 1'b1;
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (s.bready) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_cap_d;
    wready_d  = (wstate_d == W_IDLE) && !w_cap_d;
  end

  // A fresh rising edge sets STAT even when the same bit is being cleared.
  always_comb begin
    out_d   = out_q;
    ie_d    = ie_q;
    w1c     = '0;
    if (wr_fire && wr_strb0) begin
      case (wr_sel)
        2'd1:    out_d = wr_data[OUT_W-1:0];
        2'd2:    w1c   = wr_data[IN_W-1:0];
        2'd3:    ie_d  = wr_data[IN_W-1:0];
        default: ;
      endcase
    end
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    stat_d  = (stat_q & ~w1c) | (sync2_q & ~prev_q);
    irq_d   = |(stat_q & ie_q);
  end

  always_comb begin
    case (s.araddr[3:2])
      2'd0:    rd_mux = 32'(sync2_q);
      2'd1:    rd_mux = 32'(out_q);
      2'd2:    rd_mux = 32'(stat_q);
      default: rd_mux = 32'(ie_q);
    endcase
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (s.arvalid && arready_q) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = rd_mux;
        end
      end
      R_DATA: begin
        if (s.rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awsel_q   <= '0;
      wdata_q   <= '0;
      wstrb0_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      stat_q    <= '0;
      ie_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      awsel_q   <= awsel_d;
      wdata_q   <= wdata_d;
      wstrb0_q  <= wstrb0_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      stat_q    <= stat_d;
      ie_q      <= ie_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
    end
  end

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = 2'b00;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = 2'b00;
  assign gpio_out  = out_q;
  assign irq       = irq_q;

  assign unused_bits = ^{s.awaddr, s.araddr, s.wdata, s.wstrb, wr_data};
endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// Randomized self-checking bench for axi_lite_gpio_slave; a register-level
// model (OUT, IE, STAT, pin) predicts every bus read and pin observation.
module tb_axi_lite_gpio_slave;
  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] gpio_in;
  logic [1:0] gpio_out;
  logic       irq;

  always #5 clk = ~clk;

  axi_lite_gpio_slave_if #(.ADDR_W(4)) bus ();

  axi_lite_gpio_slave #(.ADDR_W(4), .IN_W(1), .OUT_W(2)) dut (
    .clk(clk), .rst(rst), .s(bus.slave),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] m_out;
  logic       m_ie;

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode,
                           output logic [1:0] resp, output int nb);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    int aw_start = (mode == 2) ? 3 : 0;
    int w_start  = (mode == 1) ? 3 : 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      bus.awvalid = !aw_done && (cyc >= aw_start);
      bus.awaddr  = addr;
      bus.wvalid  = !w_done && (cyc >= w_start);
      bus.wdata   = data;
      bus.wstrb   = strb;
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(posedge clk);
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      cyc++;
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    nb   = 0;
    resp = 2'bxx;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.bvalid === 1'b1) begin
        nb++;
        resp = bus.bresp;
      end
    end
    bus.bready = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp,
                          output bit stable, output int beats);
    int cyc = 0;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    while (bus.arready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    data   = bus.rdata;
    resp   = bus.rresp;
    stable = (bus.rvalid === 1'b1);
    if (hold == 0) bus.rready = 1'b1;
    for (int i = 2; i <= hold; i++) begin
      @(negedge clk);
      stable = stable && (bus.rvalid === 1'b1) && (bus.rdata === data) && (bus.rresp === 2'b00);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.rready = 1'b1;
    end
    beats = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.rvalid === 1'b1) beats++;
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] resp;
    int nb, lat;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq, gpio_out} !== 8'h00)
      $display("FAIL reset_outputs: got %b required 00000000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq, gpio_out});
    else n_pass++;
    n_chk++;
    if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 0", bus.rdata); else n_pass++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Make OUT, IE, STAT and irq non-zero so the mid-write reset has something to clear.
    bus_write(4'h4, 32'h3, 4'hf, 0, resp, nb);
    bus_write(4'hC, 32'h1, 4'hf, 0, resp, nb);
    gpio_in = 1'b1;
    lat = 0;
    while (irq !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    n_chk++;
    if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b required 1", irq); else n_pass++;
    gpio_in = 1'b0;
    repeat (4) @(negedge clk);
    bus.awaddr  = 4'h4;
    bus.awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.bvalid, gpio_out, irq} !== 4'b0000)
      $display("FAIL midwrite_reset: got bvalid/out/irq %b required 0000", {bus.bvalid, gpio_out, irq});
    else n_pass++;
    rst = 1'b1;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.bvalid === 1'b1) nb++;
    end
    n_chk++;
    if (nb !== 0) $display("FAIL no_resp_after_reset: got %0d bvalid cycles required 0", nb); else n_pass++;
    m_out = 2'b00;
    m_ie  = 1'b0;
    bus_write(4'h4, 32'h1, 4'hf, 0, resp, nb);
    m_out = 2'b01;
    n_chk++;
    if (nb !== 1 || resp !== 2'b00 || gpio_out !== m_out)
      $display("FAIL post_reset_write: got nb=%0d resp=%b out=%b required nb=1 resp=00 out=%b",
               nb, resp, gpio_out, m_out);
    else n_pass++;
  endtask

  task automatic test_write_modes();
    logic [1:0]  resp;
    logic [31:0] rd, data;
    logic [3:0]  addr, strb;
    logic [1:0]  want_rresp;
    bit          stable;
    int          nb, beats, mode;
    logic [1:0]  vals [3] = '{2'b10, 2'b01, 2'b11};
    for (int k = 0; k < 3; k++) begin
      bus_write(4'h4, 32'(vals[k]), 4'hf, k, resp, nb);
      m_out = vals[k];
      n_chk++;
      if (gpio_out !== m_out || nb !== 1 || resp !== 2'b00)
        $display("FAIL write_mode%0d: got out=%b nb=%0d resp=%b required out=%b nb=1 resp=00",
                 k, gpio_out, nb, resp, m_out);
      else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0:       addr = 4'h0;
        1:       addr = 4'h4 | 4'($urandom_range(0, 3));
        default: addr = 4'hC;
      endcase
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 2);
      bus_write(addr, data, strb, mode, resp, nb);
      if (strb[0] && addr[3:2] == 2'd1) m_out = data[1:0];
      if (strb[0] && addr[3:2] == 2'd3) m_ie  = data[0];
      n_chk++;
      if (gpio_out !== m_out || nb !== 1 || resp !== 2'b00)
        $display("FAIL rand_write%0d: got out=%b nb=%0d resp=%b required out=%b nb=1 resp=00",
                 k, gpio_out, nb, resp, m_out);
      else n_pass++;
      bus_read(addr, 0, rd, want_rresp, stable, beats);
      n_chk++;
      if (rd !== ((addr[3:2] == 2'd1) ? 32'(m_out) : (addr[3:2] == 2'd3) ? 32'(m_ie) : 32'h0))
        $display("FAIL rand_readback%0d: got %h at addr %h", k, rd, addr);
      else n_pass++;
    end
  endtask

  task automatic test_read_hold();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit          stable;
    int          beats;
    bus_read(4'h4, 5, rd, resp, stable, beats);
    n_chk++;
    if (rd !== 32'(m_out) || resp !== 2'b00 || !stable || beats !== 1)
      $display("FAIL read_hold: got data=%h resp=%b stable=%0d beats=%0d required data=%h resp=00 stable=1 beats=1",
               rd, resp, stable, beats, 32'(m_out));
    else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit          stable;
    int          nb, beats, lat;
    bus_write(4'hC, 32'h1, 4'hf, 0, resp, nb);
    m_ie = 1'b1;
    @(negedge clk);
    gpio_in = 1'b1;
    lat = 0;
    while (irq !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    n_chk++;
    if (lat < 4 || lat > 5) $display("FAIL irq_latency: got %0d cycles required 4..5", lat); else n_pass++;
    bus_read(4'h8, 0, rd, resp, stable, beats);
    n_chk++;
    if (rd !== 32'h1) $display("FAIL stat_set: got %h required 1", rd); else n_pass++;
    bus_write(4'h8, 32'h1, 4'hf, 0, resp, nb);
    bus_read(4'h8, 0, rd, resp, stable, beats);
    n_chk++;
    if (rd !== 32'h0 || irq !== 1'b0) $display("FAIL stat_clear: got stat=%h irq=%b required 0 0", rd, irq);
    else n_pass++;
    gpio_in = 1'b0;
    bus_write(4'hC, 32'h0, 4'hf, 0, resp, nb);
    m_ie = 1'b0;
    gpio_in = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (irq !== 1'b0) $display("FAIL irq_masked: got %b required 0", irq); else n_pass++;
    bus_read(4'h8, 0, rd, resp, stable, beats);
    n_chk++;
    if (rd !== 32'h1) $display("FAIL stat_masked: got %h required 1", rd); else n_pass++;
    bus_write(4'h8, 32'h1, 4'hf, 0, resp, nb);
    gpio_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit          stable;
    int          beats, nb;
    @(negedge clk);
    gpio_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // The W1C lands on the third edge after the pin rises, as the edge reaches STAT.
    bus.awaddr  = 4'h8;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'h1;
    bus.wstrb   = 4'hf;
    bus.wvalid  = 1'b1;
    n_chk++;
    if ({bus.awready, bus.wready} !== 2'b11) $display("FAIL setwin_ready: got %b required 11", {bus.awready, bus.wready});
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    @(negedge clk);
    bus.bready  = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(4'h8, 0, rd, resp, stable, beats);
    n_chk++;
    if (rd !== 32'h1) $display("FAIL set_wins: got %h required 1", rd); else n_pass++;
    bus_write(4'h8, 32'h1, 4'hf, 0, resp, nb);
  endtask

  task automatic test_wstrb();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit          stable;
    int          nb, beats;
    bus_write(4'h4, 32'h3, 4'h0, 0, resp, nb);
    n_chk++;
    if (gpio_out !== m_out || resp !== 2'b00 || nb !== 1)
      $display("FAIL wstrb0: got out=%b resp=%b nb=%0d required out=%b resp=00 nb=1", gpio_out, resp, nb, m_out);
    else n_pass++;
    repeat (4) @(negedge clk);
    bus_read(4'h0, 0, rd, resp, stable, beats);
    n_chk++;
    if (rd !== 32'h1) $display("FAIL read_in: got %h required 1", rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [1:0]  resp, old_out;
    bit          stable;
    int          beats;
    old_out = m_out;
    @(negedge clk);
    bus.awaddr  = 4'h4;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'(~old_out);
    bus.wstrb   = 4'h1;
    bus.wvalid  = 1'b1;
    bus.araddr  = 4'h4;
    bus.arvalid = 1'b1;
    n_chk++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
      $display("FAIL b2b_ready: got %b required 111", {bus.awready, bus.wready, bus.arready});
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    m_out = ~old_out;
    n_chk++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'(old_out) || bus.bvalid !== 1'b1)
      $display("FAIL same_cycle_read: got rvalid=%b rdata=%h bvalid=%b required 1 %h 1",
               bus.rvalid, bus.rdata, bus.bvalid, 32'(old_out));
    else n_pass++;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    n_chk++;
    if ({bus.bvalid, bus.rvalid} !== 2'b00 || gpio_out !== m_out)
      $display("FAIL b2b_done: got bv/rv=%b out=%b required 00 out=%b", {bus.bvalid, bus.rvalid}, gpio_out, m_out);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      bus_read(4'h4, 0, rd, resp, stable, beats);
      n_chk++;
      if (rd !== 32'(m_out) || beats !== 1)
        $display("FAIL b2b_read%0d: got %h beats=%0d required %h beats=1", k, rd, beats, 32'(m_out));
      else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    gpio_in     = 1'b0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    m_out = 2'b00;
    m_ie  = 1'b0;
    test_reset();
    test_write_modes();
    test_read_hold();
    test_irq();
    test_set_wins();
    test_wstrb();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
